// File: rtl/dsp_mac_seq.sv
`default_nettype none
// ============================================================================
// Module   : dsp_mac_seq
// Purpose  : Sequences a pipelined DSP slice as a multiply-accumulate engine;
//            streams N operand pairs in, returns the drained accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_mac_seq #(
    parameter int DATA_W = 18,
    parameter int LEN_W  = 10,
    parameter int P_LAT  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] dsp_a,
    output logic [DATA_W-1:0] dsp_b,
    output logic [7:0]        dsp_opmode,
    input  logic [47:0]       dsp_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [47:0]       out_data
);

    localparam logic [7:0] C_OP_CLR   = 8'h00;
    localparam logic [7:0] C_OP_FIRST = 8'h01;
    localparam logic [7:0] C_OP_HOLD  = 8'h08;
    localparam logic [7:0] C_OP_ACC   = 8'h09;
    localparam int         C_CNT_W    = (P_LAT < 1) ? 1 : $clog2(P_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [LEN_W-1:0]    r_remaining;
    logic                r_first;
    logic [C_CNT_W-1:0]  r_drain_cnt;
    logic [7:0]          r_op_d1;
    logic [7:0]          r_opmode;
    logic [DATA_W-1:0]   r_dsp_a;
    logic [DATA_W-1:0]   r_dsp_b;
    logic [47:0]         r_out_data;
    logic                w_accept;

    assign w_accept   = in_valid && in_ready;
    assign dsp_a      = r_dsp_a;
    assign dsp_b      = r_dsp_b;
    assign dsp_opmode = r_opmode;
    assign out_data   = r_out_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b1;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                in_ready = 1'b1;
                if (in_valid && (r_remaining == LEN_W'(1))) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Opmode trails A/B by one cycle: stage d1 tags the accept cycle, the
    // output register aligns it with the DSP's A1 register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_d1  <= C_OP_CLR;
            r_opmode <= C_OP_CLR;
        end else begin
            if (w_accept) begin
                r_op_d1 <= r_first ? C_OP_FIRST : C_OP_ACC;
            end else if (r_state == S_IDLE) begin
                r_op_d1 <= C_OP_CLR;
            end else begin
                r_op_d1 <= C_OP_HOLD;
            end

            case (w_next)
                S_IDLE:  r_opmode <= C_OP_CLR;
                S_DONE:  r_opmode <= C_OP_HOLD;
                default: r_opmode <= r_op_d1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= '0;
            r_first     <= 1'b0;
            r_drain_cnt <= '0;
            r_dsp_a     <= '0;
            r_dsp_b     <= '0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_remaining <= len;
                        r_first     <= 1'b1;
                        if (len == '0) begin
                            r_out_data <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_dsp_a     <= in_a;
                        r_dsp_b     <= in_b;
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_first     <= 1'b0;
                        if (r_remaining == LEN_W'(1)) begin
                            r_drain_cnt <= C_CNT_W'(P_LAT);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_out_data <= dsp_p;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - C_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dsp_mac_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dsp_mac_seq
// Purpose  : Scoreboard bench for dsp_mac_seq driving a behavioural DSP slice.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsp_mac_seq;

    localparam int DATA_W = 18;
    localparam int LEN_W  = 10;
    localparam int P_LAT  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [LEN_W-1:0]  len = '0;
    logic              busy;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_a = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic [DATA_W-1:0] dsp_a;
    logic [DATA_W-1:0] dsp_b;
    logic [7:0]        dsp_opmode;
    logic [47:0]       dsp_p;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [47:0]       out_data;

    always #5 clk = ~clk;

    dsp_mac_seq #(.DATA_W(DATA_W), .LEN_W(LEN_W), .P_LAT(P_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_p(dsp_p),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    // DSP slice: A1REG, MREG, OPMODEREG and PREG stages.
    logic [DATA_W-1:0] m_a1 = '0, m_b1 = '0;
    logic [47:0]       m_m = '0, m_p = '0;
    logic [7:0]        m_op = '0;
    always @(posedge clk) begin
        m_a1 <= dsp_a;
        m_b1 <= dsp_b;
        m_m  <= 48'(m_a1) * 48'(m_b1);
        m_op <= dsp_opmode;
        m_p  <= ((m_op[1:0] == 2'b01) ? m_m : 48'd0) + (m_op[3] ? m_p : 48'd0);
    end
    assign dsp_p = m_p;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [47:0] data;
        int          lat;
        int          start;
    } exp_t;
    exp_t sb[$];

    logic [7:0] op_log [0:4095];
    int         acc_cnt   = 0;
    int         pulse_cnt = 0;
    logic       prev_valid = 1'b0;

    function automatic logic [7:0] op_at(input int c);
        return op_log[c[11:0]];
    endfunction

    // Monitor: logs opmode slots, counts accepts and pops the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        op_log[cyc[11:0]] = dsp_opmode;
        if (in_valid && in_ready) acc_cnt++;
        if (out_valid && !prev_valid) begin
            pulse_cnt++;
            if (sb.size() > 0 && sb[0].lat >= 0)
                check("latency", 64'(cyc - sb[0].start), 64'(sb[0].lat));
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %0d expected none", out_data);
            end else begin
                e = sb.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
            end
        end
        prev_valid = out_valid;
    end

    logic [DATA_W-1:0] pa [0:7];
    logic [DATA_W-1:0] pb [0:7];
    int                last_start = 0;

    task automatic send_pair(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        bit got = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!got) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = !busy && (sb.size() == 0);
        end
        if (!ok) check("idle_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int n, input int gap, input logic [47:0] expv,
                           input int lat, input bit push, input bit wait_done);
        exp_t e;
        start = 1'b1;
        len = LEN_W'(n);
        last_start = cyc;
        if (push) begin
            e.data = expv;
            e.lat = lat;
            e.start = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            send_pair(pa[i], pb[i]);
            if (gap > 0 && i < n - 1) repeat (gap) begin @(posedge clk); #1; end
        end
        if (wait_done) wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0, a0, s;
        bit seen;

        #2 rst = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_opmode", 64'(dsp_opmode), 64'h00);
        check("rst_dsp_a", 64'(dsp_a), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back len=3
        pa[0] = 2; pb[0] = 3; pa[1] = 4; pb[1] = 5; pa[2] = 6; pb[2] = 7;
        p0 = pulse_cnt;
        run_job(3, 0, 48'd68, 3 + P_LAT + 2, 1'b1, 1'b1);
        s = last_start;
        check("op_slot1_first", 64'(op_at(s + 3)), 64'h01);
        check("op_slot2_acc", 64'(op_at(s + 4)), 64'h09);
        check("op_slot3_acc", 64'(op_at(s + 5)), 64'h09);
        check("op_after_hold", 64'(op_at(s + 6)), 64'h08);
        check("one_pulse", 64'(pulse_cnt - p0), 64'd1);

        // Same pairs with two-cycle bubbles
        run_job(3, 2, 48'd68, -1, 1'b1, 1'b1);
        s = last_start;
        check("bubble_hold_a", 64'(op_at(s + 4)), 64'h08);
        check("bubble_hold_b", 64'(op_at(s + 5)), 64'h08);
        check("bubble_acc", 64'(op_at(s + 6)), 64'h09);

        pa[0] = 1000; pb[0] = 1000;
        run_job(1, 0, 48'd1000000, 1 + P_LAT + 2, 1'b1, 1'b1);

        // len=0: in_valid held high, nothing may be accepted
        in_valid = 1'b1;
        in_a = 18'd5;
        in_b = 18'd5;
        a0 = acc_cnt;
        run_job(0, 0, 48'd0, 1, 1'b1, 1'b1);
        in_valid = 1'b0;
        check("len0_no_accept", 64'(acc_cnt - a0), 64'd0);

        pa[0] = 262143; pb[0] = 262143; pa[1] = 262143; pb[1] = 262143;
        run_job(2, 0, 48'd137437904898, 2 + P_LAT + 2, 1'b1, 1'b1);

        // Back-pressure on the result port; start pulses must be ignored
        out_ready = 1'b0;
        pa[0] = 1; pb[0] = 2; pa[1] = 3; pb[1] = 4;
        run_job(2, 0, 48'd14, 2 + P_LAT + 2, 1'b1, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
            if (!seen) begin @(posedge clk); #1; end
        end
        if (!seen) check("out_valid_timeout", 64'd0, 64'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", 64'(out_data), 64'd14);
            @(posedge clk);
            #1;
            start = (k == 1);
            len = LEN_W'(1);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("released_busy", 64'(busy), 64'd0);
        check("released_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("start_ignored", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of a 4-pair job
        pa[0] = 10; pb[0] = 11; pa[1] = 12; pb[1] = 13;
        run_job(4, 0, 48'd0, -1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_opmode", 64'(dsp_opmode), 64'h00);
        check("midrst_dsp_a", 64'(dsp_a), 64'd0);
        check("midrst_dsp_b", 64'(dsp_b), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        pa[0] = 3; pb[0] = 3;
        run_job(1, 0, 48'd9, 1 + P_LAT + 2, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
